// File: rtl/sys_array_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : sys_array_seq_if
// Purpose  : Bundle of sequencer-side signals for the MNIST systolic-array
//            layer: run control, input-vector pacing, weight-ROM addressing,
//            array control strobes and the tile-result handshake.
// Modports : master - the sequencer (drives addresses, strobes, status)
//            slave  - the surrounding datapath / control that it drives
// Revision : 1.0 - initial release
// ============================================================================
interface sys_array_seq_if #(
    parameter int K_WIDTH    = 10,
    parameter int ADDR_WIDTH = 14,
    parameter int T_WIDTH    = 4
);
    // Run control
    logic                  start;
    logic                  busy;
    logic                  done;
    // Input-vector source handshake
    logic                  x_valid;
    logic                  x_ready;
    logic [K_WIDTH-1:0]    k_idx;
    // Weight ROM
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_en;
    // Array control
    logic                  array_en;
    logic                  acc_clr;
    logic                  bias_add;
    // Tile result handshake
    logic                  out_valid;
    logic                  out_ready;
    logic [T_WIDTH-1:0]    tile_idx;

    modport master (
        input  start, x_valid, out_ready,
        output busy, done, x_ready, k_idx, w_addr, w_en,
               array_en, acc_clr, bias_add, out_valid, tile_idx
    );

    modport slave (
        output start, x_valid, out_ready,
        input  busy, done, x_ready, k_idx, w_addr, w_en,
               array_en, acc_clr, bias_add, out_valid, tile_idx
    );
endinterface
`default_nettype wire

// File: rtl/sys_array_seq.sv
`default_nettype none
// ============================================================================
// Module   : sys_array_seq
// Purpose  : Per-tile sequencer for the systolic-array layer. For each output
//            tile it clears the accumulators, streams IN_LEN weight-ROM
//            addresses paced by the input-vector source, waits DRAIN_CYC
//            cycles for the array pipeline, pulses the bias add and presents
//            the tile result with a valid/ready handshake. A done pulse ends
//            the run.
// Ports    : clk  - clock, rising edge
//            rst  - synchronous active-high reset
//            bus  - sys_array_seq_if.master (start/busy/done, x_valid/x_ready/
//                   k_idx, w_addr/w_en, array_en/acc_clr/bias_add,
//                   out_valid/out_ready/tile_idx)
// Revision : 1.0 - initial release
// ============================================================================
module sys_array_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int SIZE       = 16,
    parameter int IN_LEN     = 784,
    parameter int OUT_TILES  = 1,
    parameter int DRAIN_CYC  = 32,
    parameter int ADDR_WIDTH = 14,
    parameter int K_WIDTH    = 10,
    parameter int T_WIDTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    sys_array_seq_if.master bus
);

    // DATA_WIDTH and SIZE are carried for top-level consistency only; they
    // take part in the elaboration-time range check below.
    generate
        if (DATA_WIDTH < 1 || SIZE < 1 || IN_LEN < 1 || OUT_TILES < 1 ||
            DRAIN_CYC < 1 ||
            (OUT_TILES * IN_LEN) >= (2 ** ADDR_WIDTH) ||
            IN_LEN > (2 ** K_WIDTH) || OUT_TILES > (2 ** T_WIDTH)) begin : g_bad_params
            $error("sys_array_seq: parameter set out of range");
        end
    endgenerate

    localparam int                  c_dcnt_w = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [K_WIDTH-1:0]  c_k_last = K_WIDTH'(IN_LEN - 1);
    localparam logic [T_WIDTH-1:0]  c_t_last = T_WIDTH'(OUT_TILES - 1);
    localparam logic [c_dcnt_w-1:0] c_d_last = c_dcnt_w'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_DRAIN = 3'd3,
        S_BIAS  = 3'd4,
        S_OUT   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [K_WIDTH-1:0]    r_k;
    logic [K_WIDTH-1:0]    w_k_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [T_WIDTH-1:0]    r_tile;
    logic [T_WIDTH-1:0]    w_tile_nxt;
    logic [c_dcnt_w-1:0]   r_dcnt;
    logic [c_dcnt_w-1:0]   w_dcnt_nxt;
    logic                  r_array_en;
    logic                  w_issue;

    // A weight read is issued on every accepted input element.
    assign w_issue = (r_state == S_LOAD) && bus.x_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_k        <= '0;
            r_addr     <= '0;
            r_tile     <= '0;
            r_dcnt     <= '0;
            r_array_en <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_k        <= w_k_nxt;
            r_addr     <= w_addr_nxt;
            r_tile     <= w_tile_nxt;
            r_dcnt     <= w_dcnt_nxt;
            // The ROM output is registered, so the array consumes one cycle
            // after the read is issued.
            r_array_en <= w_issue;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_addr_nxt  = r_addr;
        w_tile_nxt  = r_tile;
        w_dcnt_nxt  = r_dcnt;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_CLEAR;
                    w_tile_nxt  = '0;
                    w_addr_nxt  = '0;
                end
            end
            S_CLEAR: begin
                w_k_nxt     = '0;
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (bus.x_valid) begin
                    // Running address: after the last element it already
                    // points at the base of the next tile.
                    w_addr_nxt = r_addr + ADDR_WIDTH'(1);
                    if (r_k == c_k_last) begin
                        w_k_nxt     = '0;
                        w_dcnt_nxt  = '0;
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_k_nxt = r_k + K_WIDTH'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (r_dcnt == c_d_last) begin
                    w_state_nxt = S_BIAS;
                end else begin
                    w_dcnt_nxt = r_dcnt + c_dcnt_w'(1);
                end
            end
            S_BIAS: begin
                w_state_nxt = S_OUT;
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    if (r_tile < c_t_last) begin
                        w_tile_nxt  = r_tile + T_WIDTH'(1);
                        w_state_nxt = S_CLEAR;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_tile_nxt  = '0;
                w_addr_nxt  = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.x_ready   = w_issue;
    assign bus.w_en      = w_issue;
    assign bus.k_idx     = r_k;
    assign bus.w_addr    = r_addr;
    assign bus.tile_idx  = r_tile;
    assign bus.array_en  = r_array_en;
    assign bus.acc_clr   = (r_state == S_CLEAR);
    assign bus.bias_add  = (r_state == S_BIAS);
    assign bus.out_valid = (r_state == S_OUT);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_sys_array_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sys_array_seq
// Purpose  : Self-checking bench for sys_array_seq. Instance A uses
//            IN_LEN=4, OUT_TILES=2, DRAIN_CYC=3; instance B uses 1/1/1.
//            Cycle n is the cycle following rising edge n-1; start for a run
//            is sampled at edge 0. Outputs are sampled mid-cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sys_array_seq;

    localparam int MAXC = 400;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic x_valid = 1'b0;
    logic out_ready = 1'b0;

    always #5 clk = ~clk;

    sys_array_seq_if #(.K_WIDTH(10), .ADDR_WIDTH(14), .T_WIDTH(4)) bus_a ();
    sys_array_seq_if #(.K_WIDTH(10), .ADDR_WIDTH(14), .T_WIDTH(4)) bus_b ();

    assign bus_a.start     = start_a;
    assign bus_a.x_valid   = x_valid;
    assign bus_a.out_ready = out_ready;
    assign bus_b.start     = start_b;
    assign bus_b.x_valid   = x_valid;
    assign bus_b.out_ready = out_ready;

    sys_array_seq #(
        .DATA_WIDTH(8), .SIZE(16), .IN_LEN(4), .OUT_TILES(2), .DRAIN_CYC(3),
        .ADDR_WIDTH(14), .K_WIDTH(10), .T_WIDTH(4)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );

    sys_array_seq #(
        .DATA_WIDTH(8), .SIZE(16), .IN_LEN(1), .OUT_TILES(1), .DRAIN_CYC(1),
        .ADDR_WIDTH(14), .K_WIDTH(10), .T_WIDTH(4)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    // Observation word: [35] x_ready [34] acc_clr [33] w_en [32] array_en
    // [31] bias_add [30] out_valid [29] busy [28] done [27:24] tile_idx
    // [23:14] k_idx [13:0] w_addr
    logic [35:0] obs_a;
    logic [35:0] obs_b;
    assign obs_a = {bus_a.x_ready, bus_a.acc_clr, bus_a.w_en, bus_a.array_en,
                    bus_a.bias_add, bus_a.out_valid, bus_a.busy, bus_a.done,
                    bus_a.tile_idx, bus_a.k_idx, bus_a.w_addr};
    assign obs_b = {bus_b.x_ready, bus_b.acc_clr, bus_b.w_en, bus_b.array_en,
                    bus_b.bias_add, bus_b.out_valid, bus_b.busy, bus_b.done,
                    bus_b.tile_idx, bus_b.k_idx, bus_b.w_addr};

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [35:0] pk(input bit acc, input bit wen, input bit aen,
                                       input bit bias, input bit ov, input bit busy,
                                       input bit done, input int tile, input int k,
                                       input int addr);
        return {wen, acc, wen, aen, bias, ov, busy, done, 4'(tile), 10'(k), 14'(addr)};
    endfunction

    task automatic check(input string name, input int c, input logic [35:0] act,
                         input logic [35:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: observed %h, required %h", name, c, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input bit act, input bit exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0b, required %0b", name, act, exp);
        end
    endtask

    // ---------------- vector table for the nominal two-tile run ----------
    typedef struct {
        bit          st;
        bit          xv;
        bit          ordy;
        logic [35:0] exp;
    } vec_t;

    vec_t        tab[23];
    logic [35:0] tab6[8];

    // ---------------- behavioural reference model ------------------------
    bit          xv_s[MAXC];
    bit          or_s[MAXC];
    bit          st_s[MAXC];
    bit          e_acc[MAXC];
    bit          e_wen[MAXC];
    bit          e_aen[MAXC];
    bit          e_bias[MAXC];
    bit          e_ov[MAXC];
    bit          e_busy[MAXC];
    bit          e_done[MAXC];
    int          e_tile[MAXC];
    int          e_k[MAXC];
    int          e_addr[MAXC];
    logic [35:0] log_obs[MAXC];
    int          t_end;

    task automatic mark(input int t, input int tl, input int addr, input int k);
        e_busy[t] = 1'b1;
        e_tile[t] = tl;
        e_addr[t] = addr;
        e_k[t]    = k;
    endtask

    // Lays the run out on a timeline, phase by phase, from the given
    // per-cycle x_valid / out_ready stimulus.
    task automatic model(input int in_len, input int tiles, input int drain);
        int t;
        int addr;
        int k;
        for (int i = 0; i < MAXC; i++) begin
            e_acc[i] = 0; e_wen[i] = 0; e_aen[i] = 0; e_bias[i] = 0;
            e_ov[i] = 0; e_busy[i] = 0; e_done[i] = 0;
            e_tile[i] = 0; e_k[i] = 0; e_addr[i] = 0;
        end
        t = 1;
        addr = 0;
        for (int tl = 0; tl < tiles; tl++) begin
            mark(t, tl, tl * in_len, 0); e_acc[t] = 1; t++;
            k = 0;
            while (k < in_len) begin
                mark(t, tl, addr, k);
                if (xv_s[t]) begin
                    e_wen[t] = 1; k++; addr++;
                end
                t++;
            end
            for (int d = 0; d < drain; d++) begin
                mark(t, tl, addr, 0); t++;
            end
            mark(t, tl, addr, 0); e_bias[t] = 1; t++;
            do begin
                mark(t, tl, addr, 0); e_ov[t] = 1; t++;
            end while (!or_s[t-1]);
        end
        mark(t, tiles - 1, addr, 0); e_done[t] = 1; t++;
        t_end = t;
        for (int i = 1; i < MAXC; i++) e_aen[i] = e_wen[i-1];
    endtask

    task automatic gen_random(input int in_len, input int tiles, input int drain);
        for (int i = 0; i < MAXC; i++) begin
            xv_s[i] = (i > MAXC / 2) ? 1'b1 : ($urandom_range(0, 2) != 0);
            or_s[i] = (i > MAXC / 2) ? 1'b1 : ($urandom_range(0, 1) == 1);
        end
        model(in_len, tiles, drain);
        // Extra start pulses only while busy (including the done cycle).
        for (int i = 0; i < MAXC; i++)
            st_s[i] = (i == 0) ? 1'b1 : (e_busy[i] && ($urandom_range(0, 5) == 0));
    endtask

    task automatic directed(input int xv_lo_first, input int xv_lo_last,
                            input int or_lo_first, input int or_lo_last);
        for (int i = 0; i < MAXC; i++) begin
            xv_s[i] = !(i >= xv_lo_first && i <= xv_lo_last);
            or_s[i] = !(i >= or_lo_first && i <= or_lo_last);
            st_s[i] = (i == 0);
        end
        model(4, 2, 3);
    endtask

    task automatic run(input string name, input bit sel);
        logic [35:0] o;
        for (int c = 0; c <= t_end + 2; c++) begin
            @(negedge clk);
            if (sel) start_b = st_s[c];
            else     start_a = st_s[c];
            x_valid   = xv_s[c];
            out_ready = or_s[c];
            #1;
            o = sel ? obs_b : obs_a;
            log_obs[c] = o;
            check(name, c, o, pk(e_acc[c], e_wen[c], e_aen[c], e_bias[c], e_ov[c],
                                 e_busy[c], e_done[c], e_tile[c], e_k[c], e_addr[c]));
        end
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic apply_table(input string name, input bit busy_starts);
        for (int c = 0; c < 23; c++) begin
            @(negedge clk);
            start_a   = tab[c].st | (busy_starts && (c == 5 || c == 21));
            x_valid   = tab[c].xv;
            out_ready = tab[c].ordy;
            #1;
            check(name, c, obs_a, tab[c].exp);
        end
        start_a = 1'b0;
    endtask

    initial begin
        int ov_t0;

        // acc wen aen bias ov busy done tile k addr
        tab[0]  = '{1, 1, 1, pk(0,0,0,0,0,0,0, 0,0,0)};
        tab[1]  = '{0, 1, 1, pk(1,0,0,0,0,1,0, 0,0,0)};
        tab[2]  = '{0, 1, 1, pk(0,1,0,0,0,1,0, 0,0,0)};
        tab[3]  = '{0, 1, 1, pk(0,1,1,0,0,1,0, 0,1,1)};
        tab[4]  = '{0, 1, 1, pk(0,1,1,0,0,1,0, 0,2,2)};
        tab[5]  = '{0, 1, 1, pk(0,1,1,0,0,1,0, 0,3,3)};
        tab[6]  = '{0, 1, 1, pk(0,0,1,0,0,1,0, 0,0,4)};
        tab[7]  = '{0, 1, 1, pk(0,0,0,0,0,1,0, 0,0,4)};
        tab[8]  = '{0, 1, 1, pk(0,0,0,0,0,1,0, 0,0,4)};
        tab[9]  = '{0, 1, 1, pk(0,0,0,1,0,1,0, 0,0,4)};
        tab[10] = '{0, 1, 1, pk(0,0,0,0,1,1,0, 0,0,4)};
        tab[11] = '{0, 1, 1, pk(1,0,0,0,0,1,0, 1,0,4)};
        tab[12] = '{0, 1, 1, pk(0,1,0,0,0,1,0, 1,0,4)};
        tab[13] = '{0, 1, 1, pk(0,1,1,0,0,1,0, 1,1,5)};
        tab[14] = '{0, 1, 1, pk(0,1,1,0,0,1,0, 1,2,6)};
        tab[15] = '{0, 1, 1, pk(0,1,1,0,0,1,0, 1,3,7)};
        tab[16] = '{0, 1, 1, pk(0,0,1,0,0,1,0, 1,0,8)};
        tab[17] = '{0, 1, 1, pk(0,0,0,0,0,1,0, 1,0,8)};
        tab[18] = '{0, 1, 1, pk(0,0,0,0,0,1,0, 1,0,8)};
        tab[19] = '{0, 1, 1, pk(0,0,0,1,0,1,0, 1,0,8)};
        tab[20] = '{0, 1, 1, pk(0,0,0,0,1,1,0, 1,0,8)};
        tab[21] = '{0, 1, 1, pk(0,0,0,0,0,1,1, 1,0,8)};
        tab[22] = '{0, 1, 1, pk(0,0,0,0,0,0,0, 0,0,0)};

        tab6[0] = pk(0,0,0,0,0,0,0, 0,0,0);
        tab6[1] = pk(1,0,0,0,0,1,0, 0,0,0);
        tab6[2] = pk(0,1,0,0,0,1,0, 0,0,0);
        tab6[3] = pk(0,0,1,0,0,1,0, 0,0,1);
        tab6[4] = pk(0,0,0,1,0,1,0, 0,0,1);
        tab6[5] = pk(0,0,0,0,1,1,0, 0,0,1);
        tab6[6] = pk(0,0,0,0,0,1,1, 0,0,1);
        tab6[7] = pk(0,0,0,0,0,0,0, 0,0,0);

        // Reset state, with inputs that would otherwise provoke activity.
        x_valid = 1'b1; out_ready = 1'b1; start_a = 1'b1; start_b = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_a", 0, obs_a, 36'h0);
        check("reset_b", 0, obs_b, 36'h0);
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
        repeat (2) @(negedge clk);

        // Nominal run, then the same run with start pulsed while busy.
        apply_table("nominal", 1'b0);
        apply_table("start_while_busy", 1'b1);

        // x_valid low in cycles 3-4.
        directed(3, 4, -1, -1);
        run("xvalid_gap", 1'b0);
        check("gap_k_c3", 3, {26'h0, log_obs[3][23:14]}, 36'd1);
        check("gap_k_c4", 4, {26'h0, log_obs[4][23:14]}, 36'd1);
        check_bit("gap_no_wen_c3", log_obs[3][33], 1'b0);
        check_bit("gap_no_wen_c4", log_obs[4][33], 1'b0);
        check_bit("gap_done_c23", log_obs[23][28], 1'b1);

        // out_ready low for 5 cycles of tile 0 OUT.
        directed(-1, -1, 10, 14);
        run("out_stall", 1'b0);
        ov_t0 = 0;
        for (int c = 0; c < 30; c++)
            if (log_obs[c][30] && log_obs[c][27:24] == 4'd0) ov_t0++;
        check("stall_ov_cycles", 0, 36'(ov_t0), 36'd6);
        check_bit("stall_acc_clr_c16", log_obs[16][34], 1'b1);
        check_bit("stall_done_c26", log_obs[26][28], 1'b1);

        // Reset during tile 1 DRAIN, then a fresh run from address 0.
        for (int c = 0; c < 26; c++) begin
            @(negedge clk);
            start_a   = (c == 0);
            x_valid   = 1'b1;
            out_ready = 1'b1;
            rst       = (c == 17);
            #1;
            if (c <= 17) check("abort_pre", c, obs_a, tab[c].exp);
            else         check("abort_post", c, obs_a, 36'h0);
        end
        rst = 1'b0;
        apply_table("after_abort", 1'b0);

        // Small-parameter instance, hand-written timeline.
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            start_b   = (c == 0);
            x_valid   = 1'b1;
            out_ready = 1'b1;
            #1;
            check("corner_1x1", c, obs_b, tab6[c]);
        end
        start_b = 1'b0;

        // Randomized pacing against the reference model.
        for (int r = 0; r < 20; r++) begin
            gen_random(4, 2, 3);
            run("random_a", 1'b0);
        end
        for (int r = 0; r < 10; r++) begin
            gen_random(1, 1, 1);
            run("random_b", 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
